// File: rtl/neo_sample_sequencer.sv
// neo_sample_sequencer: fetches samples from a synchronous memory and presents x[n-1], x[n], x[n+1] windows.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset      asynchronous active-high reset
//   i_start      one-cycle pass request, accepted only in IDLE
//   i_len        pass length in samples, latched on an accepted start
//   o_raddr      registered read address to the sample memory
//   i_rdata      memory read data, valid one cycle after o_raddr
//   o_x_prev     window sample x[n-1]
//   o_x_cur      window sample x[n]
//   o_x_next     window sample x[n+1]
//   o_win_valid  window valid (EMIT state)
//   i_win_ready  downstream accepts the window
//   o_busy       state is not IDLE
//   o_done       one-cycle pulse at the end of a pass
//   o_err        latched length was < 3 or > M; held until the next accepted start
//   i_abort      only when NEO_SEQ_ABORT_EN is defined: return to IDLE without done
//
// Optional feature macro: NEO_SEQ_ABORT_EN
module neo_sample_sequencer #(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [$clog2(M):0]      i_len,
    output logic [$clog2(M):0]      o_raddr,
    input  logic signed [N-1:0]     i_rdata,
    output logic signed [N-1:0]     o_x_prev,
    output logic signed [N-1:0]     o_x_cur,
    output logic signed [N-1:0]     o_x_next,
    output logic                    o_win_valid,
    input  logic                    i_win_ready,
    output logic                    o_busy,
    output logic                    o_done,
`ifdef NEO_SEQ_ABORT_EN
    input  logic                    i_abort,
`endif
    output logic                    o_err
);
    localparam int AW = $clog2(M) + 1;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    logic [2:0]          r_state;
    logic [AW-1:0]       r_len;
    logic [AW-1:0]       r_addr;
    logic [AW-1:0]       r_raddr;
    logic [1:0]          r_fill;
    logic                r_err;
    logic signed [N-1:0] r_x_prev;
    logic signed [N-1:0] r_x_cur;
    logic signed [N-1:0] r_x_next;
    logic                w_abort;
    logic                w_len_bad;
    logic [AW-1:0]       w_addr_inc;
    logic [1:0]          w_fill_inc;
`ifdef NEO_SEQ_ABORT_EN
    assign w_abort = i_abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif
    assign w_len_bad  = (i_len < AW'(3)) || (i_len > AW'(M));
    assign w_addr_inc = r_addr + AW'(1);
    // fill counts captured samples and saturates once a full window is held
    assign w_fill_inc = (r_fill == 2'd3) ? 2'd3 : r_fill + 2'd1;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_addr   <= '0;
            r_raddr  <= '0;
            r_fill   <= '0;
            r_err    <= 1'b0;
            r_x_prev <= '0;
            r_x_cur  <= '0;
            r_x_next <= '0;
        end else if (w_abort) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
            r_raddr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_len   <= i_len;
                        r_addr  <= '0;
                        r_fill  <= '0;
                        r_raddr <= '0;
                        r_err   <= w_len_bad;
                        r_state <= w_len_bad ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_x_prev <= r_x_cur;
                    r_x_cur  <= r_x_next;
                    r_x_next <= i_rdata;
                    r_addr   <= w_addr_inc;
                    r_fill   <= w_fill_inc;
                    if (w_fill_inc == 2'd3) begin
                        r_state <= S_EMIT;
                    end else if (w_addr_inc == r_len) begin
                        r_state <= S_DONE;
                        r_raddr <= '0;
                    end else begin
                        r_state <= S_FETCH;
                        r_raddr <= w_addr_inc;
                    end
                end
                S_EMIT: begin
                    // the window registers and read address stay frozen until the transfer
                    if (i_win_ready) begin
                        r_state <= (r_addr == r_len) ? S_DONE : S_FETCH;
                        r_raddr <= (r_addr == r_len) ? '0 : r_addr;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign o_raddr     = r_raddr;
    assign o_x_prev    = r_x_prev;
    assign o_x_cur     = r_x_cur;
    assign o_x_next    = r_x_next;
    assign o_win_valid = (r_state == S_EMIT);
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);
    assign o_err       = r_err;
endmodule

// File: tb/tb_neo_sample_sequencer.sv
// tb_neo_sample_sequencer: directed self-checking bench for neo_sample_sequencer.
module tb_neo_sample_sequencer;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [4:0]        len = '0;
    logic [4:0]        raddr;
    logic signed [7:0] rdata = '0;
    logic signed [7:0] x_prev, x_cur, x_next;
    logic              win_valid, win_ready = 1'b1, busy, done, err;
`ifdef NEO_SEQ_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic signed [7:0] mem [32];
    int                n_chk = 0;
    int                n_err = 0;
    neo_sample_sequencer #(.N(8), .M(16)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_len(len), .o_raddr(raddr),
        .i_rdata(rdata), .o_x_prev(x_prev), .o_x_cur(x_cur), .o_x_next(x_next),
        .o_win_valid(win_valid), .i_win_ready(win_ready), .o_busy(busy), .o_done(done),
`ifdef NEO_SEQ_ABORT_EN
        .i_abort(abort),
`endif
        .o_err(err)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rdata <= mem[raddr];
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_idle_zero(input string tag);
        chk({tag, " raddr"}, int'(raddr), 0);
        chk({tag, " x_prev"}, int'(x_prev), 0);
        chk({tag, " x_cur"}, int'(x_cur), 0);
        chk({tag, " x_next"}, int'(x_next), 0);
        chk({tag, " valid"}, int'(win_valid), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
        chk({tag, " err"}, int'(err), 0);
    endtask
    // one pass: optional stall on window stall_k, optional ignored start during window start_k
    task automatic run_pass(input int l, input int stall_k, input int start_k, input string tag);
        int  cyc, nwin, last, exp_n;
        bit  fin;
        logic [4:0] ra;
        exp_n = (l < 3 || l > 16) ? 0 : l - 2;
        cyc = 0; nwin = 0; last = 0; fin = 0;
        win_ready = 1'b1;
        len = 5'(l);
        start = 1'b1;
        for (int g = 0; g < 400 && !fin; g++) begin
            tick;
            cyc++;
            start = 1'b0;
            if (win_valid) begin
                chk({tag, " win prev"}, int'(x_prev), nwin + 1);
                chk({tag, " win cur"}, int'(x_cur), nwin + 2);
                chk({tag, " win next"}, int'(x_next), nwin + 3);
                chk({tag, " win spacing"}, (nwin == 0) ? cyc : cyc - last, (nwin == 0) ? 7 : 3);
                if (nwin == stall_k) begin
                    win_ready = 1'b0;
                    ra = raddr;
                    repeat (5) begin
                        tick;
                        cyc++;
                        chk({tag, " stall valid"}, int'(win_valid), 1);
                        chk({tag, " stall cur"}, int'(x_cur), nwin + 2);
                        chk({tag, " stall raddr"}, int'(raddr), int'(ra));
                    end
                    win_ready = 1'b1;
                end
                if (nwin == start_k) begin
                    start = 1'b1;
                    len = 5'd3;
                end
                last = cyc;
                nwin++;
            end
            if (done) begin
                fin = 1;
                chk({tag, " done timing"}, cyc, (exp_n == 0) ? 1 : last + 1);
                chk({tag, " err"}, int'(err), (exp_n == 0) ? 1 : 0);
                chk({tag, " windows"}, nwin, exp_n);
                chk({tag, " raddr in done"}, int'(raddr), 0);
            end
        end
        chk({tag, " finished"}, int'(fin), 1);
        tick;
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle done"}, int'(done), 0);
    endtask
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
        repeat (3) tick;
        chk_idle_zero("reset");
        rst = 1'b0;
        tick;
        chk_idle_zero("after reset");
        run_pass(16, -1, -1, "full");
        run_pass(2, -1, -1, "len2");
        run_pass(3, -1, -1, "len3");
        run_pass(17, -1, -1, "len17");
        run_pass(0, -1, -1, "len0");
        run_pass(16, 1, -1, "stall");
        run_pass(16, -1, 2, "start in emit");
        len = 5'd16;
        start = 1'b1;
        repeat (14) begin
            tick;
            start = 1'b0;
        end
        chk("fetch4 busy", int'(busy), 1);
        chk("fetch4 raddr", int'(raddr), 5);
        chk("fetch4 valid", int'(win_valid), 0);
        rst = 1'b1;
        tick;
        chk_idle_zero("mid reset");
        rst = 1'b0;
        repeat (3) begin
            tick;
            chk("post reset done", int'(done), 0);
        end
        run_pass(4, -1, -1, "after mid reset");
`ifdef NEO_SEQ_ABORT_EN
        len = 5'd16;
        start = 1'b1;
        repeat (19) begin
            tick;
            start = 1'b0;
        end
        chk("abort at win5 valid", int'(win_valid), 1);
        chk("abort at win5 cur", int'(x_cur), 6);
        abort = 1'b1;
        win_ready = 1'b0;
        tick;
        abort = 1'b0;
        win_ready = 1'b1;
        chk("abort busy", int'(busy), 0);
        chk("abort valid", int'(win_valid), 0);
        chk("abort done", int'(done), 0);
        tick;
        chk("abort later done", int'(done), 0);
        run_pass(5, -1, -1, "after abort");
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
